// File: rtl/hydra_host_ctrl.sv
// hydra_host_ctrl: host end of the LArPix Hydra UART link.
// Serializes config commands to a chip and matches its read replies.
module hydra_host_ctrl #(
    parameter int WIDTH        = 64,
    parameter int CLKS_PER_BIT = 4,
    parameter int TIMEOUT      = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [7:0]       cmd_chip_id,
    input  logic [7:0]       cmd_addr,
    input  logic [7:0]       cmd_wdata,
    output logic             rsp_valid,
    output logic [1:0]       rsp_status,
    output logic [7:0]       rsp_rdata,
    output logic [1:0]       rsp_fifo_flags,
    output logic             pkt_valid,
    output logic [WIDTH-1:0] pkt_data,
    output logic             tx_out,
    input  logic             rx_in
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WIDTH + 2);
    localparam int RW = $clog2(WIDTH);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_MID   = CW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_STOP  = BW'(WIDTH + 1);
    localparam logic [RW-1:0] RBIT_LAST = RW'(WIDTH - 1);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [1:0]    ST_OK     = 2'b00;
    localparam logic [1:0]    ST_TMO    = 2'b01;
    localparam logic [1:0]    ST_PAR    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_write;
    logic [7:0]       r_chip;
    logic [7:0]       r_addr;
    logic [WIDTH:0]   r_tx_shift;
    logic [CW-1:0]    r_tx_clk;
    logic [BW-1:0]    r_tx_bit;
    logic             r_tx_out;
    logic [15:0]      r_to_cnt;

    rx_state_t        r_rx_st;
    rx_state_t        w_rx_next;
    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_prev;
    logic [CW-1:0]    r_rx_cnt;
    logic [RW-1:0]    r_rx_bit;
    logic [WIDTH-1:0] r_rx_shift;

    logic [1:0]       r_rsp_status;
    logic [7:0]       r_rsp_rdata;
    logic [1:0]       r_rsp_flags;
    logic             r_pkt_valid;
    logic [WIDTH-1:0] r_pkt_data;

    logic             w_hs;
    logic [WIDTH-2:0] w_cmd_body;
    logic [WIDTH-1:0] w_cmd_pkt;
    logic             w_tx_last;
    logic             w_timeout;
    logic             w_rx_mid;
    logic             w_rx_end;
    logic             w_rx_fall;
    logic             w_rx_frame;
    logic             w_rx_par_ok;
    logic             w_match;

    assign w_hs = (r_state == S_IDLE) && cmd_valid;

    assign w_cmd_body = {{(WIDTH - 27){1'b0}},
                         cmd_write ? cmd_wdata : 8'h00,
                         cmd_addr,
                         cmd_chip_id,
                         cmd_write ? 2'b10 : 2'b11};
    assign w_cmd_pkt  = {~^w_cmd_body, w_cmd_body};

    assign w_tx_last = (r_state == S_TX) && (r_tx_clk == CLK_LAST)
                    && (r_tx_bit == BIT_STOP);
    assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == TO_LAST);

    assign w_rx_mid    = (r_rx_cnt == CLK_MID);
    assign w_rx_end    = (r_rx_cnt == CLK_LAST);
    assign w_rx_fall   = (r_rx_st == R_IDLE) && r_rx_prev && !r_rx_s2;
    assign w_rx_frame  = (r_rx_st == R_STOP) && w_rx_mid && r_rx_s2;
    assign w_rx_par_ok = r_rx_shift[WIDTH-1] == ~^r_rx_shift[WIDTH-2:0];

    // Timeout wins over a reply completing on the same cycle
    assign w_match = (r_state == S_WAIT) && !w_timeout && w_rx_frame
                  && (r_rx_shift[1:0] == 2'b11)
                  && (r_rx_shift[9:2] == r_chip)
                  && (r_rx_shift[17:10] == r_addr);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (cmd_valid) w_state_next = S_TX;
            S_TX: begin
                if (w_tx_last)
                    w_state_next = r_write ? S_DONE : S_WAIT;
            end
            S_WAIT: if (w_timeout || w_match) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_chip     <= '0;
            r_addr     <= '0;
            r_tx_shift <= '0;
            r_tx_clk   <= '0;
            r_tx_bit   <= '0;
            r_tx_out   <= 1'b1;
            r_to_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_hs) begin
                r_write    <= cmd_write;
                r_chip     <= cmd_chip_id;
                r_addr     <= cmd_addr;
                r_tx_out   <= 1'b0;
                r_tx_shift <= {1'b1, w_cmd_pkt};
                r_tx_clk   <= '0;
                r_tx_bit   <= '0;
            end else if (r_state == S_TX) begin
                if (r_tx_clk == CLK_LAST) begin
                    r_tx_clk <= '0;
                    if (r_tx_bit != BIT_STOP) begin
                        r_tx_bit   <= r_tx_bit + 1'b1;
                        r_tx_out   <= r_tx_shift[0];
                        r_tx_shift <= {1'b1, r_tx_shift[WIDTH:1]};
                    end
                end else begin
                    r_tx_clk <= r_tx_clk + 1'b1;
                end
            end
            if (r_state != S_WAIT)
                r_to_cnt <= '0;
            else if (r_to_cnt != 16'hFFFF)
                r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    always_comb begin
        w_rx_next = r_rx_st;
        unique case (r_rx_st)
            R_IDLE: if (w_rx_fall) w_rx_next = R_START;
            R_START: begin
                if (w_rx_mid && r_rx_s2)
                    w_rx_next = R_IDLE;
                else if (w_rx_end)
                    w_rx_next = R_DATA;
            end
            R_DATA: begin
                if (w_rx_end && (r_rx_bit == RBIT_LAST))
                    w_rx_next = R_STOP;
            end
            R_STOP: if (w_rx_mid) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    // The edge-detect cycle is count 0 of the start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_st    <= R_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1   <= rx_in;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_st   <= w_rx_next;
            if (r_rx_st == R_IDLE) begin
                r_rx_cnt <= w_rx_fall ? CW'(1) : '0;
                r_rx_bit <= '0;
            end else begin
                r_rx_cnt <= w_rx_end ? '0 : r_rx_cnt + 1'b1;
                if (r_rx_st == R_DATA) begin
                    if (w_rx_mid)
                        r_rx_shift <= {r_rx_s2, r_rx_shift[WIDTH-1:1]};
                    if (w_rx_end)
                        r_rx_bit <= r_rx_bit + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_status <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_flags  <= '0;
            r_pkt_valid  <= 1'b0;
            r_pkt_data   <= '0;
        end else begin
            if (w_tx_last && r_write) begin
                r_rsp_status <= ST_OK;
                r_rsp_rdata  <= '0;
                r_rsp_flags  <= '0;
            end else if (w_timeout) begin
                r_rsp_status <= ST_TMO;
                r_rsp_rdata  <= '0;
                r_rsp_flags  <= '0;
            end else if (w_match) begin
                r_rsp_status <= w_rx_par_ok ? ST_OK : ST_PAR;
                r_rsp_rdata  <= r_rx_shift[25:18];
                r_rsp_flags  <= r_rx_shift[WIDTH-3:WIDTH-4];
            end
            r_pkt_valid <= w_rx_frame && !w_match;
            if (w_rx_frame && !w_match)
                r_pkt_data <= r_rx_shift;
        end
    end

    assign cmd_ready      = (r_state == S_IDLE);
    assign rsp_valid      = (r_state == S_DONE);
    assign rsp_status     = r_rsp_status;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_fifo_flags = r_rsp_flags;
    assign pkt_valid      = r_pkt_valid;
    assign pkt_data       = r_pkt_data;
    assign tx_out         = r_tx_out;

endmodule

// File: tb/tb_hydra_host_ctrl.sv
// Scoreboard bench for hydra_host_ctrl: frames, replies, timeouts, resets.
module tb_hydra_host_ctrl;

    localparam int CPB   = 4;
    localparam int TO    = 4096;
    localparam int FRAME = 66 * CPB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_chip_id = '0;
    logic [7:0]  cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rx_in = 1'b1;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_fifo_flags;
    logic        pkt_valid;
    logic [63:0] pkt_data;
    logic        tx_out;

    hydra_host_ctrl #(.WIDTH(64), .CLKS_PER_BIT(CPB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_chip_id(cmd_chip_id),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .rsp_rdata(rsp_rdata), .rsp_fifo_flags(rsp_fifo_flags),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .tx_out(tx_out), .rx_in(rx_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [7:0] rd;
        logic [1:0] fl;
        int         at;
    } rsp_t;

    logic [63:0] q_tx[$];
    logic [63:0] q_pkt[$];
    rsp_t        q_rsp[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int tx_frames = 0;

    function automatic logic [63:0] make_pkt(input logic [1:0] t,
        input logic [7:0] chip, input logic [7:0] addr,
        input logic [7:0] d, input logic [1:0] fl);
        logic [62:0] b;
        b = 63'(t) | (63'(chip) << 2) | (63'(addr) << 10)
          | (63'(d) << 18) | (63'(fl) << 60);
        return {~^b, b};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic flag_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // TX frame decoder
    initial begin
        bit          busy;
        int          cnt;
        logic [63:0] pkt;
        busy = 0;
        cnt  = 0;
        pkt  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                busy = 0;
            end else if (!busy) begin
                if (tx_out === 1'b0) begin
                    busy = 1;
                    cnt  = 0;
                    chk("ready_low_start", 64'(cmd_ready), 64'd0);
                end
            end else begin
                cnt++;
                if (cnt % CPB == 0) begin
                    if (cnt / CPB <= 64) begin
                        pkt[cnt/CPB-1] = tx_out;
                    end else begin
                        chk("tx_stop", 64'(tx_out), 64'd1);
                        chk("ready_low_stop", 64'(cmd_ready), 64'd0);
                        if (q_tx.size() == 0) flag_fail("tx_unexpected");
                        else chk("tx_pkt", pkt, q_tx.pop_front());
                        busy = 0;
                        tx_frames++;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n && rsp_valid === 1'b1) begin
            if (q_rsp.size() == 0) begin
                flag_fail("rsp_unexpected");
            end else begin
                rsp_t r;
                r = q_rsp.pop_front();
                chk("rsp_status", 64'(rsp_status), 64'(r.st));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rd));
                chk("rsp_flags", 64'(rsp_fifo_flags), 64'(r.fl));
                if (r.at >= 0) chk("rsp_time", 64'(cyc), 64'(r.at));
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n && pkt_valid === 1'b1) begin
            if (q_pkt.size() == 0) flag_fail("pkt_unexpected");
            else chk("pkt_data", pkt_data, q_pkt.pop_front());
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_rsp(input logic [1:0] s, input logic [7:0] d,
                            input logic [1:0] f, input int at);
        rsp_t r;
        r.st = s;
        r.rd = d;
        r.fl = f;
        r.at = at;
        q_rsp.push_back(r);
    endtask

    task automatic issue(input bit wr, input logic [7:0] chip,
                         input logic [7:0] addr, input logic [7:0] wd,
                         output int hc);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) flag_fail("cmd_ready_wait");
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_chip_id = chip;
        cmd_addr    = addr;
        cmd_wdata   = wd;
        q_tx.push_back(make_pkt(wr ? 2'b10 : 2'b11, chip, addr,
                                wr ? wd : 8'h00, 2'b00));
        @(negedge clk);
        hc          = cyc;
        cmd_valid   = 1'b0;
        cmd_chip_id = 8'($urandom);
        cmd_addr    = 8'($urandom);
        cmd_wdata   = 8'($urandom);
    endtask

    task automatic wait_tx(input int target);
        int n;
        n = 0;
        while (tx_frames < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tx_frames < target) flag_fail("tx_frame_wait");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_rsp.size() + q_pkt.size() + q_tx.size()) != 0
               && n < TO + 4000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(q_rsp.size() + q_pkt.size() + q_tx.size()),
            64'd0);
        q_rsp.delete();
        q_pkt.delete();
        q_tx.delete();
    endtask

    task automatic send_frame(input logic [63:0] p, input bit stop);
        @(negedge clk);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            rx_in = p[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Issue a read and answer it after extra unmatched traffic
    task automatic read_cycle(input logic [7:0] chip, input logic [7:0] addr,
                              input int delay, input int extras,
                              input bit badpar);
        int          hc;
        int          t;
        logic [63:0] p;
        logic [7:0]  d;
        logic [1:0]  f;
        t = tx_frames;
        issue(1'b0, chip, addr, 8'($urandom), hc);
        wait_tx(t + 1);
        repeat (delay) @(negedge clk);
        for (int k = 0; k < extras; k++) begin
            if (k % 2 == 0)
                p = make_pkt(2'b00, 8'($urandom), 8'($urandom),
                             8'($urandom), 2'($urandom));
            else
                p = make_pkt(2'b11, chip ^ 8'(1 << $urandom_range(0, 7)),
                             addr, 8'($urandom), 2'b00);
            q_pkt.push_back(p);
            send_frame(p, 1'b1);
        end
        d = 8'($urandom);
        f = 2'($urandom);
        p = make_pkt(2'b11, chip, addr, d, f);
        if (badpar) p[63] = ~p[63];
        push_rsp(badpar ? 2'b10 : 2'b00, d, f, -1);
        send_frame(p, 1'b1);
        drain();
    endtask

    initial begin
        int          hc;
        int          t;
        logic [63:0] p;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", 64'(tx_out), 64'd1);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
        chk("rst_rsp_status", 64'(rsp_status), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_flags", 64'(rsp_fifo_flags), 64'd0);
        chk("rst_pkt_data", pkt_data, 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        issue(1'b1, 8'h12, 8'h05, 8'hA7, hc);
        push_rsp(2'b00, 8'h00, 2'b00, hc + FRAME);
        drain();

        t = tx_frames;
        issue(1'b0, 8'h12, 8'h05, 8'h00, hc);
        wait_tx(t + 1);
        repeat (200) @(negedge clk);
        push_rsp(2'b00, 8'h3C, 2'b10, -1);
        send_frame(make_pkt(2'b11, 8'h12, 8'h05, 8'h3C, 2'b10), 1'b1);
        drain();

        issue(1'b0, 8'h44, 8'h21, 8'h00, hc);
        push_rsp(2'b01, 8'h00, 2'b00, hc + FRAME + TO);
        drain();

        t = tx_frames;
        issue(1'b0, 8'h12, 8'h05, 8'h00, hc);
        wait_tx(t + 1);
        p = make_pkt(2'b00, 8'h12, 8'h05, 8'h77, 2'b01);
        q_pkt.push_back(p);
        send_frame(p, 1'b1);
        p = make_pkt(2'b11, 8'h13, 8'h05, 8'h55, 2'b00);
        q_pkt.push_back(p);
        send_frame(p, 1'b1);
        push_rsp(2'b00, 8'h99, 2'b01, -1);
        send_frame(make_pkt(2'b11, 8'h12, 8'h05, 8'h99, 2'b01), 1'b1);
        drain();

        read_cycle(8'h31, 8'h0A, 50, 0, 1'b1);

        t = tx_frames;
        issue(1'b0, 8'h31, 8'h0B, 8'h00, hc);
        wait_tx(t + 1);
        send_frame(make_pkt(2'b11, 8'h31, 8'h0B, 8'h5A, 2'b11), 1'b0);
        push_rsp(2'b01, 8'h00, 2'b00, hc + FRAME + TO);
        drain();

        @(negedge clk);
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        repeat (400) @(negedge clk);

        issue(1'b1, 8'h07, 8'h08, 8'h09, hc);
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midtx_tx_out", 64'(tx_out), 64'd1);
        chk("midtx_ready", 64'(cmd_ready), 64'd1);
        q_tx.delete();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        issue(1'b1, 8'h07, 8'h08, 8'h0A, hc);
        push_rsp(2'b00, 8'h00, 2'b00, hc + FRAME);
        drain();

        t = tx_frames;
        issue(1'b0, 8'h66, 8'h02, 8'h00, hc);
        wait_tx(t + 1);
        fork
            send_frame(make_pkt(2'b11, 8'h66, 8'h02, 8'h11, 2'b00), 1'b1);
        join_none
        repeat (120) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrx_ready", 64'(cmd_ready), 64'd1);
        chk("midrx_tx_out", 64'(tx_out), 64'd1);
        repeat (200) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        read_cycle(8'h66, 8'h02, 10, 0, 1'b0);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                issue(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), hc);
                push_rsp(2'b00, 8'h00, 2'b00, hc + FRAME);
                if ($urandom_range(0, 1) == 1) begin
                    p = make_pkt(2'b01, 8'($urandom), 8'($urandom),
                                 8'($urandom), 2'($urandom));
                    q_pkt.push_back(p);
                    send_frame(p, 1'b1);
                end
                drain();
            end else begin
                read_cycle(8'($urandom), 8'($urandom),
                           $urandom_range(0, 300), $urandom_range(0, 2),
                           $urandom_range(0, 3) == 0);
            end
        end

        repeat (400) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
